alu4_req_scheduler: RTL and testbench
=====================================

// Module: alu4_req_scheduler
// PURPOSE
//  Shares one 4-bit ALU datapath between two requesters (ch0, ch1) with round-robin arbitration.
//  Runs one operation at a time. DIV uses an iterative 4-step restoring divider; every other op
//  takes one cycle. The tagged 8-bit result and flags are held until the consumer takes them.
//  Sits between the tile's command sources and the result/readback path.
// PARAMETERS
//  ENC_KEY   8'hAB  XOR key for ENC: result = {a,b} ^ ENC_KEY
//  FIXED_PRI 0      0 = round-robin; 1 = ch0 always wins when both channels are valid
// PORTS
//  clk           in   1  clock; single clock domain
//  rst_n         in   1  asynchronous, active-low reset
//  req0_valid    in   1  ch0 command valid
//  req0_ready    out  1  ch0 command accepted this cycle when req0_valid is also high
//  req0_op       in   4  ch0 opcode
//  req0_a        in   4  ch0 operand a
//  req0_b        in   4  ch0 operand b
//  req1_*        --   -  ch1 ports; same set and meaning as the ch0 ports
//  rsp_valid     out  1  response valid
//  rsp_ready     in   1  consumer accepts response
//  rsp_id        out  1  channel that issued the command
//  rsp_result    out  8  result
//  rsp_carry     out  1  carry (ADD) or borrow (SUB); 0 for all other ops
//  rsp_overflow  out  1  signed overflow (ADD/SUB); 0 for all other ops
//  rsp_err       out  1  illegal opcode (9..15) or divide by zero
//  busy          out  1  high whenever state != IDLE
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT(a), 8 ENC.
//  Reset: state=IDLE, last_grant=1 (ch0 wins first), all rsp_* = 0, busy = 0, both ready = 0.
//  FSM states: IDLE, DIV, RESP.
//   - IDLE: reqX_ready = granted channel only (combinational from valids and last_grant).
//     On accept, latch op/a/b/id and update last_grant.
//     Non-DIV op, or DIV with b==0: compute result and go to RESP (rsp_valid rises next cycle).
//     DIV with b!=0: go to DIV with step counter = 0.
//   - DIV: one quotient bit per cycle, MSB first. After 4 cycles, go to RESP.
//     Accept-to-rsp_valid latency is 5 for DIV and 1 for every other op.
//   - RESP: rsp_* stable while rsp_valid=1 && !rsp_ready. On rsp_ready, go to IDLE and drop rsp_valid.
//     No new accept in the same cycle, so sustained throughput is one op per 2 cycles.
//  Arbitration:
//   - Only one channel is valid: that channel is granted.
//   - Both valid, round-robin: the channel != last_grant is granted.
//   - Both valid, FIXED_PRI=1: ch0 is granted.
//   - Both ready outputs are 0 outside IDLE. A request waiting in another state has priority fixed
//     by last_grant at its next IDLE cycle.
//  Arithmetic (unused upper nibble = 0):
//   - ADD: s = a+b (5b); result = s[3:0]; carry = s[4];
//     ovf = a3&b3&~s3 | ~a3&~b3&s3.
//   - SUB: d = {a3,a} - {b3,b}; result = d[3:0]; carry = d[4];
//     ovf = a3&~b3&~d3 | ~a3&b3&d3.
//   - MUL: result = a*b (8b). DIV: result = {quotient, remainder}.
//   - AND/OR/XOR/NOT: 4-bit results. ENC: 8-bit XOR with ENC_KEY.
//  Errors: DIV by 0 -> result 0x00, rsp_err=1. Opcodes 9..15 -> result 0x00, rsp_err=1.
//   Both complete with latency 1.
//  Reset mid-operation: the in-flight command and any pending response are discarded; no partial output.
//  Changes on reqX_* while not ready have no effect. Operands are taken only on the accept edge.
// STRUCTURE
//  Shared header alu4_defs.vh holds:
//   - opcode localparams OP_ADD..OP_ENC
//   - state encodings ST_IDLE/ST_DIV/ST_RESP
//   - default ENC_KEY
//  One sub-module: alu4_core, combinational single-cycle ops (everything except iterative DIV),
//   outputs {result, carry, overflow, illegal}.
//  Arbiter, FSM and restoring divider (4-bit remainder register, step counter) live in the top.
// TESTING
//  1. Reset, ch0 ADD a=9 b=8 -> accept cycle N; rsp at N+1: result 0x01, carry 1, ovf 1, id 0.
//  2. ch1 DIV a=13 b=4 -> busy for 5 cycles; rsp at N+5: result 0x31, err 0. DIV b=0 -> 0x00, err 1 at N+1.
//  3. Both valid continuously with SUB 3-5 (ch0) and MUL 15*15 (ch1) -> grants alternate 0,1,0,1.
//     ch0 rsp = 0x0E carry 1 ovf 0; ch1 rsp = 0xE1. FIXED_PRI=1 -> only ch0 is granted.
//  4. Hold rsp_ready=0 for 6 cycles after ENC a=0 b=0 -> rsp_result stays 0xAB, ready stays 0.
//     Release -> IDLE next cycle.
//  5. Opcode 0xC -> result 0x00, err 1. Assert rst_n=0 during DIV step 2 -> all outputs 0.
//     First post-reset grant goes to ch0.

Source files
------------

// File: rtl/alu4_req_scheduler_pkg.sv
// Shared definitions for the two-channel 4-bit ALU scheduler: opcodes, FSM states,
// the default ENC key and the packed response bundle.
package alu4_req_scheduler_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_ENC = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [7:0] ENC_KEY_DEFAULT = 8'hAB;
  localparam logic [1:0] DIV_LAST_STEP   = 2'd3;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       err;
  } alu_rsp_t;

endpackage

// File: rtl/alu4_req_scheduler_core.sv
// Single-cycle ALU ops (everything except the iterative divide). For DIV it only
// flags divide-by-zero; the quotient comes from the divider in the top.
module alu4_req_scheduler_core
  import alu4_req_scheduler_pkg::*;
#(
  parameter logic [7:0] ENC_KEY = ENC_KEY_DEFAULT
) (
  input  logic [3:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output alu_rsp_t   rsp
);

  logic [4:0] sum;
  logic [4:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {a[3], a} - {b[3], b};

  always_comb begin
    // NOTE: default every field first so no opcode path leaves rsp unassigned (no latch).
    rsp = '0;
    case (op)
      OP_ADD: begin
        rsp.result   = {4'h0, sum[3:0]};
        rsp.carry    = sum[4];
        rsp.overflow = (a[3] & b[3] & ~sum[3]) | (~a[3] & ~b[3] & sum[3]);
      end
      OP_SUB: begin
        rsp.result   = {4'h0, dif[3:0]};
        rsp.carry    = dif[4];
        rsp.overflow = (a[3] & ~b[3] & ~dif[3]) | (~a[3] & b[3] & dif[3]);
      end
      OP_MUL:  rsp.result = {4'h0, a} * {4'h0, b};
      OP_DIV:  rsp.err    = (b == 4'h0);
      OP_AND:  rsp.result = {4'h0, a & b};
      OP_OR:   rsp.result = {4'h0, a | b};
      OP_XOR:  rsp.result = {4'h0, a ^ b};
      OP_NOT:  rsp.result = {4'h0, ~a};
      OP_ENC:  rsp.result = {a, b} ^ ENC_KEY;
      default: rsp.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu4_req_scheduler.sv
// Two-channel round-robin front end for one shared 4-bit ALU, with a 4-step
// restoring divider and a held response slot.
module alu4_req_scheduler
  import alu4_req_scheduler_pkg::*;
#(
  parameter logic [7:0] ENC_KEY   = ENC_KEY_DEFAULT,
  parameter bit         FIXED_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_overflow,
  output logic       rsp_err,
  output logic       busy
);

  state_e     state, state_nxt;
  logic       last_grant;
  logic       gnt_valid;
  logic       gnt_id;
  logic       cur_id;
  logic [3:0] sel_op, sel_a, sel_b;
  logic       start_div;
  alu_rsp_t   core_rsp;
  alu_rsp_t   rsp_q;
  logic [3:0] div_q;
  logic [3:0] div_b;
  logic [3:0] div_rem;
  logic [3:0] rem_nxt;
  logic [4:0] rem_shift;
  logic       div_ge;
  logic [1:0] step;

  assign sel_op    = gnt_id ? req1_op : req0_op;
  assign sel_a     = gnt_id ? req1_a  : req0_a;
  assign sel_b     = gnt_id ? req1_b  : req0_b;
  assign start_div = (sel_op == OP_DIV) && (sel_b != 4'h0);

  alu4_req_scheduler_core #(.ENC_KEY(ENC_KEY)) u_core (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .rsp (core_rsp)
  );

  // Restoring step: div_q shifts the dividend out MSB first and the quotient in LSB first.
  // The trial difference is below 16 whenever it is kept, so 4-bit wrap-around is exact.
  assign rem_shift = {div_rem, div_q[3]};
  assign div_ge    = rem_shift >= {1'b0, div_b};
  assign rem_nxt   = div_ge ? (rem_shift[3:0] - div_b) : rem_shift[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gnt_valid) state_nxt = start_div ? ST_DIV : ST_RESP;
      ST_DIV:  if (step == DIV_LAST_STEP) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = FIXED_PRI ? 1'b0 : ~last_grant;
      end else if (req0_valid) begin
        gnt_valid = 1'b1;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
    req0_ready = gnt_valid && !gnt_id;
    req1_ready = gnt_valid && gnt_id;
    busy       = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      div_q      <= '0;
      div_b      <= '0;
      div_rem    <= '0;
      step       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_q      <= '0;
    end else begin
      // NOTE: non-blocking in clocked blocks so every register samples pre-edge values.
      case (state)
        ST_IDLE: if (gnt_valid) begin
          last_grant <= gnt_id;
          if (start_div) begin
            cur_id  <= gnt_id;
            div_q   <= sel_a;
            div_b   <= sel_b;
            div_rem <= '0;
            step    <= '0;
          end else begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id;
            rsp_q     <= core_rsp;
          end
        end
        ST_DIV: begin
          div_q   <= {div_q[2:0], div_ge};
          div_rem <= rem_nxt;
          step    <= step + 2'd1;
          if (step == DIV_LAST_STEP) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_q     <= '{result: {div_q[2:0], div_ge, rem_nxt}, carry: 1'b0,
                           overflow: 1'b0, err: 1'b0};
          end
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_id    <= 1'b0;
          rsp_q     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_result   = rsp_q.result;
  assign rsp_carry    = rsp_q.carry;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_err      = rsp_q.err;

endmodule

// File: tb/tb_alu4_req_scheduler.sv
// Bench for alu4_req_scheduler: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu4_req_scheduler;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       ovf;
    logic       err;
  } exp_t;

  logic       clk, rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req0_a, req0_b, req1_op, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_overflow, rsp_err, busy;
  logic [7:0] rsp_result;

  logic       f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id;
  logic       f_rsp_carry, f_rsp_overflow, f_rsp_err, f_busy;
  logic [7:0] f_rsp_result;

  int n_cmp = 0;
  int n_err = 0;
  int f_accepts = 0;

  // model state: response slot, in-flight divide countdown, arbitration memory
  bit   m_pending, m_inflight, m_last, m_id;
  int   m_wait;
  exp_t m_exp;
  bit   idle, gv, gid;
  int   cur_op, cur_a, cur_b;

  alu4_req_scheduler #(.ENC_KEY(8'hAB), .FIXED_PRI(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .busy(busy)
  );

  alu4_req_scheduler #(.ENC_KEY(8'hAB), .FIXED_PRI(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(1'b1), .req0_ready(f_req0_ready), .req0_op(4'd0), .req0_a(4'd1), .req0_b(4'd2),
    .req1_valid(1'b1), .req1_ready(f_req1_ready), .req1_op(4'd2), .req1_a(4'd3), .req1_b(4'd3),
    .rsp_valid(f_rsp_valid), .rsp_ready(1'b1), .rsp_id(f_rsp_id), .rsp_result(f_rsp_result),
    .rsp_carry(f_rsp_carry), .rsp_overflow(f_rsp_overflow), .rsp_err(f_rsp_err), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int sx4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Reference ALU from the arithmetic definitions (signed ints, not bit slices).
  function automatic exp_t ref_alu(input int op, input int a, input int b);
    exp_t e;
    int   r;
    e = '0;
    case (op)
      0: begin
        r = a + b;
        e.result = 8'(r % 16);
        e.carry  = (r > 15);
        r = sx4(a) + sx4(b);
        e.ovf = (r > 7) || (r < -8);
      end
      1: begin
        r = sx4(a) - sx4(b);
        e.result = 8'(r & 15);
        e.carry  = (r < 0);
        e.ovf    = (r > 7) || (r < -8);
      end
      2: e.result = 8'(a * b);
      3: if (b == 0) e.err = 1'b1;
         else e.result = 8'((a / b) * 16 + (a % b));
      4: e.result = 8'(a & b);
      5: e.result = 8'(a | b);
      6: e.result = 8'(a ^ b);
      7: e.result = 8'(15 - a);
      8: e.result = 8'((a * 16 + b) ^ 171);
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Per-cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", 32'({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow,
                                  rsp_err, busy, req0_ready, req1_ready}), 32'd0);
      m_pending = 0; m_inflight = 0; m_last = 1; m_id = 0; m_wait = 0; m_exp = '0;
    end else begin
      idle = !m_inflight && !m_pending;
      gv   = idle && (req0_valid || req1_valid);
      gid  = (req0_valid && req1_valid) ? !m_last : (req1_valid && !req0_valid);
      check("req0_ready", 32'(req0_ready), 32'(gv && !gid));
      check("req1_ready", 32'(req1_ready), 32'(gv && gid));
      check("busy", 32'(busy), 32'(!idle));
      check("rsp_valid", 32'(rsp_valid), 32'(m_pending));
      if (m_pending)
        check("rsp_fields", 32'({rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_err}),
              32'({m_id, m_exp}));
      if (m_pending) begin
        if (rsp_ready) m_pending = 0;
      end else if (m_inflight) begin
        m_wait--;
        if (m_wait == 0) begin m_inflight = 0; m_pending = 1; end
      end else if (gv) begin
        cur_op = gid ? int'(req1_op) : int'(req0_op);
        cur_a  = gid ? int'(req1_a)  : int'(req0_a);
        cur_b  = gid ? int'(req1_b)  : int'(req0_b);
        m_last = gid;
        m_id   = gid;
        m_exp  = ref_alu(cur_op, cur_a, cur_b);
        if (cur_op == 3 && cur_b != 0) begin m_inflight = 1; m_wait = 4; end
        else m_pending = 1;
      end
      check("fix_req1_ready", 32'(f_req1_ready), 32'd0);
      if (f_rsp_valid) check("fix_rsp_id", 32'(f_rsp_id), 32'd0);
      if (f_req0_ready) f_accepts++;
    end
  end

  task automatic do_cmd(input bit ch, input int op, input int a, input int b, input int exp_lat,
                        input logic [7:0] exp_res, input bit exp_c, input bit exp_v, input bit exp_e);
    int n;
    bit ok;
    @(posedge clk); #1;
    if (ch) begin req1_valid = 1; req1_op = 4'(op); req1_a = 4'(a); req1_b = 4'(b); end
    else    begin req0_valid = 1; req0_op = 4'(op); req0_a = 4'(a); req0_b = 4'(b); end
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = ch ? req1_ready : req0_ready;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      ok = rsp_valid;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("lit_result", 32'(rsp_result), 32'(exp_res));
    check("lit_flags", 32'({rsp_carry, rsp_overflow, rsp_err}), 32'({exp_c, exp_v, exp_e}));
    check("lit_id", 32'(rsp_id), 32'(ch));
  endtask

  initial begin
    int  prev, grants, g;
    bit  seen0, seen1, ok;
    exp_t e;

    // pin the reference model with hand-computed values
    e = ref_alu(0, 9, 8);  check("model_add", 32'(e), 32'({8'h01, 1'b1, 1'b1, 1'b0}));
    e = ref_alu(1, 3, 5);  check("model_sub", 32'(e), 32'({8'h0E, 1'b1, 1'b0, 1'b0}));
    e = ref_alu(2, 15, 15); check("model_mul", 32'(e), 32'({8'hE1, 3'b000}));
    e = ref_alu(3, 13, 4); check("model_div", 32'(e), 32'({8'h31, 3'b000}));
    e = ref_alu(8, 0, 0);  check("model_enc", 32'(e), 32'({8'hAB, 3'b000}));
    e = ref_alu(12, 5, 6); check("model_illegal", 32'(e), 32'({8'h00, 3'b001}));

    rst_n = 0; rsp_ready = 1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    do_cmd(0, 0, 9, 8, 1, 8'h01, 1, 1, 0);
    do_cmd(1, 3, 13, 4, 5, 8'h31, 0, 0, 0);
    do_cmd(0, 3, 7, 0, 1, 8'h00, 0, 0, 1);

    // both channels continuously valid: grants must alternate
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 4'd1; req0_a = 4'd3;  req0_b = 4'd5;
    req1_valid = 1; req1_op = 4'd2; req1_a = 4'd15; req1_b = 4'd15;
    prev = 2; grants = 0; seen0 = 0; seen1 = 0;
    repeat (16) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        g = int'(req1_ready);
        if (prev != 2) check("rr_alternate", 32'(g), 32'(prev == 0));
        prev = g;
        grants++;
      end
      if (rsp_valid && !rsp_id && !seen0) begin
        check("rr_sub_rsp", 32'({rsp_result, rsp_carry, rsp_overflow}), 32'({8'h0E, 2'b10}));
        seen0 = 1;
      end
      if (rsp_valid && rsp_id && !seen1) begin
        check("rr_mul_rsp", 32'(rsp_result), 32'h0E1);
        seen1 = 1;
      end
    end
    check("rr_grants", 32'(grants >= 6 && seen0 && seen1), 32'd1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(posedge clk);

    // response held under back-pressure, no accepts while waiting
    #1 rsp_ready = 0;
    do_cmd(0, 8, 0, 0, 1, 8'hAB, 0, 0, 0);
    @(posedge clk); #1;
    req1_valid = 1; req1_op = 4'd0; req1_a = 4'd1; req1_b = 4'd1;
    repeat (6) begin
      @(negedge clk);
      check("hold_result", 32'({rsp_valid, rsp_result}), 32'({1'b1, 8'hAB}));
      check("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1; req1_valid = 0;
    @(negedge clk);
    check("release_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("idle_after_release", 32'({busy, rsp_valid}), 32'd0);

    do_cmd(0, 12, 5, 6, 1, 8'h00, 0, 0, 1);

    // reset during divide step 2
    @(posedge clk); #1;
    req1_valid = 1; req1_op = 4'd3; req1_a = 4'd11; req1_b = 4'd3;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = req1_ready; end
    check("div_accept", 32'(ok), 32'd1);
    @(posedge clk); #1 req1_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    check("reset_mid_div", 32'({rsp_valid, rsp_result, rsp_err, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    req0_valid = 1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1; req1_op = 4'd0; req1_a = 4'd2; req1_b = 4'd2;
    @(negedge clk);
    check("first_grant_ch0", 32'({req0_ready, req1_ready}), 32'b10);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(posedge clk);

    // randomized traffic with one reset pulse mid-stream
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      rst_n      = (i != 200);
      req0_valid = (i != 200) && ($urandom_range(0, 99) < 60);
      req1_valid = (i != 200) && ($urandom_range(0, 99) < 60);
      req0_op    = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
      req1_op    = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
      req0_a     = 4'($urandom_range(0, 15));
      req0_b     = 4'($urandom_range(0, 15));
      req1_a     = 4'($urandom_range(0, 15));
      req1_b     = 4'($urandom_range(0, 15));
      rsp_ready  = ($urandom_range(0, 99) < 70);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("fix_progress", 32'(f_accepts > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
